lane_capture_buffer: RTL and testbench

- Downstream consumer of the 12 single-bit lane outputs (OA..OL) produced by the mod4Bports mesh top.
- Registers the lane word every cycle and enqueues words into a small FIFO, either every cycle or only when the word changes.
- Presents the queued words on a valid/ready stream to the next stage, with occupancy reporting and sticky overflow detection.

---
 rtl/lane_capture_pkg.sv | 22 ++
 rtl/lane_sync_fifo.sv | 66 ++++++
 rtl/lane_capture_buffer.sv | 91 +++++++++
 tb/tb_lane_capture_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_capture_pkg.sv
// Shared types and defaults for the lane capture buffer.
// LANE_CAPTURE_PARITY_EN adds an even-parity bit to each stored word.
package lane_capture_pkg;

  localparam int LANES_DEF = 12;
  localparam int DEPTH_DEF = 8;

`ifdef LANE_CAPTURE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef logic [LANES_DEF-1:0] lane_word_t;

  function automatic logic lane_parity(
    input lane_word_t w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/lane_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered occupancy counter.
// Build option LANE_CAPTURE_PARITY_EN only changes W at the instantiation.
module lane_sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PW = LVL_W - 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign level_o = lvl_q;

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the push needs, so full does not block it.
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    unique case (1'b1)
      do_push & ~do_pop: lvl_d = lvl_q + LVL_W'(1);
      ~do_push & do_pop: lvl_d = lvl_q - LVL_W'(1);
      default:           lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      if (do_push) mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/lane_capture_buffer.sv
// Captures the 12-lane mesh word and queues it onto a valid/ready stream.
// Define LANE_CAPTURE_PARITY_EN to append even parity as the data MSB.
module lane_capture_buffer
  import lane_capture_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       lanes_i,
  input  logic                   sample_en_i,
  input  logic                   on_change_i,
  output logic [LANES+PAR_W-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LVL_W-1:0]       level_o,
  output logic                   overflow_o,
  input  logic                   clr_ovf_i
);

  localparam int DW = LANES + PAR_W;

  logic [LANES-1:0] cap_q;
  logic [LANES-1:0] last_q, last_d;
  logic             cap_vld_q;
  logic             ovf_q, ovf_d;
  logic             push_req, push_ok;
  logic             pop, drop;
  logic             full, empty;
  logic [DW-1:0]    wdata;

`ifdef LANE_CAPTURE_PARITY_EN
  assign wdata = {^cap_q, cap_q};
`else
  assign wdata = cap_q;
`endif

  assign pop      = ~empty & out_ready_i;
  assign push_req = cap_vld_q
                  & (~on_change_i | (cap_q != last_q));
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    last_d = last_q;
    ovf_d  = ovf_q;
    if (push_ok) last_d = cap_q;
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      last_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cap_q     <= lanes_i;
      cap_vld_q <= sample_en_i;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  lane_sync_fifo #(
    .W     (DW),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (out_data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign out_valid_o = ~empty;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_lane_capture_buffer.sv
// Randomised and directed bench for lane_capture_buffer against a queue model.
// Parity checks are compiled in with LANE_CAPTURE_PARITY_EN.
module tb_lane_capture_buffer;
  import lane_capture_pkg::*;

  localparam int LANES = 12;
  localparam int DEPTH = 8;
  localparam int LVL_W = 4;
  localparam int DW    = LANES + PAR_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [LANES-1:0] lanes = '0;
  logic             en = 1'b0;
  logic             chg = 1'b0;
  logic             rdy = 1'b0;
  logic             clr = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic [LVL_W-1:0] level;
  logic             ovf;

  lane_capture_buffer #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lanes_i     (lanes),
    .sample_en_i (en),
    .on_change_i (chg),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (rdy),
    .level_o     (level),
    .overflow_o  (ovf),
    .clr_ovf_i   (clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: one pipeline slot, a queue of words, last-enqueued word, flag.
  logic [LANES-1:0] m_cap;
  logic [LANES-1:0] m_last;
  logic             m_vld;
  logic             m_ovf;
  logic [LANES-1:0] q[$];

  function automatic logic [DW-1:0] expw(input logic [LANES-1:0] w);
`ifdef LANE_CAPTURE_PARITY_EN
    return {lane_parity(w), w};
`else
    return w;
`endif
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    cmp("valid", 32'(out_valid), 32'(q.size() > 0));
    cmp("level", 32'(level), 32'(q.size()));
    cmp("ovf", 32'(ovf), 32'(m_ovf));
    if (q.size() > 0) cmp("data", 32'(out_data), 32'(expw(q[0])));
  endtask

  task automatic model_reset();
    m_cap  = '0;
    m_last = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    q.delete();
  endtask

  task automatic step(input logic [LANES-1:0] l, input logic e,
                      input logic c, input logic r, input logic cl);
    logic pop, req, drop, full;
    lanes = l;
    en    = e;
    chg   = c;
    rdy   = r;
    clr   = cl;
    full  = (q.size() == DEPTH);
    pop   = (q.size() > 0) && r;
    req   = m_vld && (!c || (m_cap != m_last));
    drop  = 1'b0;
    if (pop) void'(q.pop_front());
    if (req) begin
      if (!full || pop) begin
        q.push_back(m_cap);
        m_last = m_cap;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    m_cap = l;
    m_vld = e;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  // Asserted off the clock edge so the async clear is seen on its own.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_valid", 32'(out_valid), 0);
    cmp("rst_level", 32'(level), 0);
    cmp("rst_ovf", 32'(ovf), 0);
    cmp("rst_data", 32'(out_data), 0);
    en  = 1'b0;
    rdy = 1'b0;
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [LANES-1:0] got[$];
  logic [LANES-1:0] rl;
  logic             rc;
  int               rp;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cmp("init_valid", 32'(out_valid), 0);
    cmp("init_level", 32'(level), 0);
    cmp("init_data", 32'(out_data), 0);
    rst_n = 1'b1;

    // Every-cycle mode, streaming
    step(12'h001, 1, 0, 1, 0);
    cmp("ec_lat", 32'(out_valid), 0);
    step(12'h002, 1, 0, 1, 0);
    cmp("ec_d1", 32'(out_data), 32'(expw(12'h001)));
    step(12'h003, 1, 0, 1, 0);
    cmp("ec_d2", 32'(out_data), 32'(expw(12'h002)));
    cmp("ec_l2", 32'(level), 1);
    step(12'h000, 0, 0, 1, 0);
    cmp("ec_d3", 32'(out_data), 32'(expw(12'h003)));
    cmp("ec_l3", 32'(level), 1);
    step(12'h000, 0, 0, 1, 0);
    cmp("ec_end", 32'(out_valid), 0);

    // Change mode
    do_reset();
    got.delete();
    repeat (3) begin
      step(12'h000, 1, 1, 1, 0);
      cmp("chg_zero", 32'(out_valid), 0);
    end
    for (int i = 0; i < 16; i++) begin
      step(i < 10 ? 12'hA5A : 12'h5A5, i < 13, 1, 1, 0);
      if (out_valid) got.push_back(out_data[LANES-1:0]);
    end
    cmp("chg_cnt", 32'(got.size()), 2);
    cmp("chg_w0", 32'(got.size() > 0 ? got[0] : 12'hFFF), 32'h A5A);
    cmp("chg_w1", 32'(got.size() > 1 ? got[1] : 12'hFFF), 32'h5A5);

    // Overflow and drain
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(12'h100 + 12'(i), 1, 0, 0, 0);
      cmp("ovf_lvl", 32'(level), 32'(i < 8 ? i : 8));
      cmp("ovf_flag", 32'(ovf), 32'(i >= 9));
    end
    step(12'h000, 0, 0, 0, 1);
    cmp("ovf_setwins", 32'(ovf), 1);
    cmp("ovf_full", 32'(level), 8);
    for (int k = 0; k < 8; k++) begin
      cmp("ovf_drain", 32'(out_data), 32'(expw(12'h100 + 12'(k))));
      step(12'h000, 0, 0, 1, 0);
    end
    cmp("ovf_empty", 32'(out_valid), 0);
    cmp("ovf_sticky", 32'(ovf), 1);
    step(12'h000, 0, 0, 0, 1);
    cmp("ovf_clr", 32'(ovf), 0);

    // Full with simultaneous pop
    do_reset();
    for (int i = 0; i < 9; i++) step(12'h200 + 12'(i), 1, 0, 0, 0);
    cmp("fp_full", 32'(level), 8);
    step(12'h000, 0, 0, 1, 0);
    cmp("fp_lvl", 32'(level), 8);
    cmp("fp_ovf", 32'(ovf), 0);
    for (int k = 0; k < 8; k++) begin
      cmp("fp_order", 32'(out_data), 32'(expw(12'h201 + 12'(k))));
      step(12'h000, 0, 0, 1, 0);
    end

`ifdef LANE_CAPTURE_PARITY_EN
    do_reset();
    step(12'h007, 1, 0, 1, 0);
    step(12'h003, 1, 0, 1, 0);
    cmp("par_7", 32'(out_data), 32'h1007);
    step(12'h000, 0, 0, 1, 0);
    cmp("par_3", 32'(out_data), 32'h0003);
`endif

    // Reset with words queued
    do_reset();
    for (int i = 0; i < 5; i++) step(12'h300 + 12'(i), 1, 0, 0, 0);
    step(12'h000, 0, 0, 0, 0);
    cmp("mr_lvl", 32'(level), 5);
    do_reset();
    step(12'h0AB, 1, 0, 0, 0);
    cmp("mr_lat", 32'(out_valid), 0);
    step(12'h000, 0, 0, 0, 0);
    cmp("mr_v", 32'(out_valid), 1);
    cmp("mr_d", 32'(out_data), 32'(expw(12'h0AB)));

    // Random traffic
    rl = '0;
    rc = 1'b0;
    rp = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) rp = int'($urandom_range(0, 100));
      if (n % 37 == 0) rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rl = 12'($urandom);
      step(rl, $urandom_range(0, 3) != 0, rc,
           int'($urandom_range(0, 99)) < rp,
           $urandom_range(0, 15) == 0);
      if (n % 997 == 500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
